logic_unit_arbiter: RTL and testbench

//  Shares one 32-bit bitwise logic unit (AND/OR/XOR/NOR) among NREQ requesters.
//  - Fair round-robin arbitration; valid/ready handshake on every requester port.
//  - One registered result slot with valid/ready output and requester ID tag.
//  - Sits between the decode/issue paths and the shared ALU logic slice.

---
 rtl/logic_arb_pkg.sv | 10 +
 rtl/rr_picker.sv | 21 ++
 rtl/logic_unit_arbiter.sv | 71 +++++++
 tb/tb_logic_unit_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/logic_arb_pkg.sv
// logic_arb_pkg: op codes and widths shared by the logic unit arbiter
package logic_arb_pkg;
  localparam int OP_W = 2;
  localparam int STALL_W = 16;
  typedef logic [OP_W-1:0] lop_t;
  localparam lop_t LOP_AND = 2'b00;
  localparam lop_t LOP_OR = 2'b01;
  localparam lop_t LOP_XOR = 2'b10;
  localparam lop_t LOP_NOR = 2'b11;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick of the first request at or after ptr
module rr_picker #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [N-1:0] rot;
  always_comb begin
    rot = N'({req, req} >> ptr);
    any = |req;
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (rot[k]) idx = IW'((int'(ptr) + k) % N);
    gnt = any ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
  end
endmodule

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin share of one bitwise logic unit with a registered result slot
// LOGIC_ARB_STATS_EN adds a saturating backpressure stall counter port.
module logic_unit_arbiter
  import logic_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ*OP_W-1:0]    req_op,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WIDTH-1:0]        rsp_data,
  output logic [$clog2(NREQ)-1:0] rsp_id
`ifdef LOGIC_ARB_STATS_EN
  ,
  output logic [STALL_W-1:0]      stall_cnt
`endif
);
  localparam int IW = $clog2(NREQ);
  logic [IW-1:0] ptr, gidx, ptr_nxt;
  logic [NREQ-1:0] gnt;
  logic any, slot_free, fire;
  logic [WIDTH-1:0] a_g, b_g, res;
  lop_t op_g;
  rr_picker #(.N(NREQ), .IW(IW)) u_pick (
    .req(req_valid),
    .ptr(ptr),
    .gnt(gnt),
    .idx(gidx),
    .any(any)
  );
  always_comb begin
    slot_free = !rsp_valid || rsp_ready;
    fire = any && slot_free;
    req_ready = (rst_n && slot_free) ? gnt : '0;
    a_g = req_a[gidx*WIDTH +: WIDTH];
    b_g = req_b[gidx*WIDTH +: WIDTH];
    op_g = req_op[gidx*OP_W +: OP_W];
    res = op_g == LOP_AND ? a_g & b_g :
          op_g == LOP_OR  ? a_g | b_g :
          op_g == LOP_XOR ? a_g ^ b_g : ~(a_g | b_g);
    ptr_nxt = (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_id <= '0;
      ptr <= '0;
    end else if (fire) begin
      rsp_valid <= 1'b1;
      rsp_data <= res;
      rsp_id <= gidx;
      ptr <= ptr_nxt;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
`ifdef LOGIC_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else if (rsp_valid && !rsp_ready && |req_valid && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: randomized and directed checks against a cycle-level reference model
module tb_logic_unit_arbiter;
  localparam int NREQ = 4;
  localparam int W = 32;
  logic clk = 0, rst_n = 0, rsp_ready = 0, rsp_valid;
  logic [NREQ-1:0] req_valid = '0, req_ready;
  logic [NREQ*W-1:0] req_a = '0, req_b = '0;
  logic [NREQ*2-1:0] req_op = '0;
  logic [W-1:0] rsp_data;
  logic [1:0] rsp_id;
`ifdef LOGIC_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif
  int tests = 0, fails = 0;
  logic m_valid;
  logic [W-1:0] m_data;
  int m_id, m_ptr, m_stall;
  logic [NREQ-1:0] exp_ready, obs_ready;

  logic_unit_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
`ifdef LOGIC_ARB_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  always #5 clk = ~clk;

  function automatic logic [W-1:0] lop(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'd0: return a & b;
      2'd1: return a | b;
      2'd2: return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_id = 0; m_ptr = 0; m_stall = 0;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
    req_a[i*W +: W] = a; req_b[i*W +: W] = b; req_op[i*2 +: 2] = op;
  endtask

  // one clock: sample req_ready mid-cycle, advance model at the edge, return at posedge+1
  task automatic tick();
    int g;
    g = (!m_valid || rsp_ready) ? pick(req_valid, m_ptr) : -1;
    exp_ready = g >= 0 ? NREQ'(1 << g) : '0;
    @(negedge clk);
    obs_ready = req_ready;
    @(posedge clk);
    if (m_valid && !rsp_ready && |req_valid && m_stall != 16'hFFFF) m_stall++;
    if (g >= 0) begin
      m_data = lop(req_op[g*2 +: 2], req_a[g*W +: W], req_b[g*W +: W]);
      m_id = g; m_valid = 1; m_ptr = (g + 1) % NREQ;
    end else if (rsp_ready) m_valid = 0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; req_valid = '1; rsp_ready = 1;
    #12;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
    tests++; if (rsp_data !== '0) begin fails++; $display("FAIL reset_data got %h want 0", rsp_data); end
    tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL reset_id got %0d want 0", rsp_id); end
    tests++; if (req_ready !== '0) begin fails++; $display("FAIL reset_ready got %b want 0", req_ready); end
    @(posedge clk); #1;
    req_valid = '0; rst_n = 1; model_reset();
  endtask

  task automatic test_basic();
    set_req(0, 32'hF0F0F0F0, 32'hFF00FF00, 2'b00);
    req_valid = 4'b0001; rsp_ready = 1;
    tick();
    tests++; if (obs_ready !== 4'b0001) begin fails++; $display("FAIL basic_ready got %b want 0001", obs_ready); end
    tests++; if (rsp_valid !== 1'b1 || rsp_data !== 32'hF000F000 || rsp_id !== 2'd0) begin
      fails++; $display("FAIL basic_rsp got v=%b d=%h id=%0d want v=1 d=F000F000 id=0", rsp_valid, rsp_data, rsp_id);
    end
    req_valid = '0;
    tick();
    tests++; if (rsp_valid !== 1'b0 || rsp_data !== 32'hF000F000) begin
      fails++; $display("FAIL basic_drain got v=%b d=%h want v=0 d=F000F000", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_round_robin();
    int p0;
    for (int i = 0; i < NREQ; i++) set_req(i, $urandom, $urandom, 2'(i));
    req_valid = '1; rsp_ready = 1; p0 = m_ptr;
    for (int k = 0; k < 8; k++) begin
      tick();
      tests++; if (obs_ready !== NREQ'(1 << ((p0 + k) % NREQ)) || rsp_id !== 2'((p0 + k) % NREQ) || rsp_data !== m_data || rsp_valid !== 1'b1) begin
        fails++; $display("FAIL rr_order k=%0d got rdy=%b id=%0d d=%h want id=%0d d=%h", k, obs_ready, rsp_id, rsp_data, (p0 + k) % NREQ, m_data);
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_ops();
    logic [W-1:0] want [4];
    want = '{32'h000000FF, 32'h00FFFFFF, 32'h00FFFF00, 32'hFF000000};
    rsp_ready = 1;
    for (int op = 0; op < 4; op++) begin
      set_req(2, 32'h0000FFFF, 32'h00FF00FF, 2'(op));
      req_valid = 4'b0100;
      tick();
      tests++; if (rsp_data !== want[op] || rsp_id !== 2'd2) begin
        fails++; $display("FAIL op%0d got %h id=%0d want %h id=2", op, rsp_data, rsp_id, want[op]);
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d0;
    logic [1:0] i0;
    int ids;
    set_req(0, $urandom, $urandom, 2'd2);
    req_valid = 4'b0001; rsp_ready = 1;
    tick();
    set_req(1, $urandom, $urandom, 2'd1);
    set_req(2, $urandom, $urandom, 2'd3);
    req_valid = 4'b0110; rsp_ready = 0;
    d0 = m_data; i0 = 2'(m_id);
    for (int k = 0; k < 5; k++) begin
      tick();
      tests++; if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_id !== i0 || obs_ready !== '0) begin
        fails++; $display("FAIL bp_hold k=%0d got v=%b d=%h id=%0d rdy=%b want v=1 d=%h id=%0d rdy=0", k, rsp_valid, rsp_data, rsp_id, obs_ready, d0, i0);
      end
    end
    rsp_ready = 1; ids = 0;
    for (int k = 0; k < 2; k++) begin
      tick();
      tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(m_id) || rsp_data !== m_data || obs_ready !== exp_ready) begin
        fails++; $display("FAIL bp_release k=%0d got v=%b id=%0d d=%h want v=1 id=%0d d=%h", k, rsp_valid, rsp_id, rsp_data, m_id, m_data);
      end
      ids += int'(rsp_id);
      req_valid = req_valid & ~obs_ready;
    end
    tests++; if (ids !== 3 || req_valid !== '0) begin
      fails++; $display("FAIL bp_served got idsum=%0d left=%b want idsum=3 left=0000", ids, req_valid);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
      tests++; if (obs_ready !== exp_ready || rsp_valid !== m_valid || rsp_data !== m_data || rsp_id !== 2'(m_id)) begin
        fails++; $display("FAIL rand c=%0d got rdy=%b v=%b d=%h id=%0d want rdy=%b v=%b d=%h id=%0d", c, obs_ready, rsp_valid, rsp_data, rsp_id, exp_ready, m_valid, m_data, m_id);
      end
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] || obs_ready[i]) begin
          req_valid[i] = $urandom_range(0, 1);
          set_req(i, $urandom, $urandom, 2'($urandom_range(0, 3)));
        end
    end
    req_valid = '0; rsp_ready = 1;
    tick();
  endtask

  task automatic test_async_reset();
    set_req(3, 32'h12345678, 32'h0F0F0F0F, 2'd1);
    req_valid = 4'b1000; rsp_ready = 1;
    tick();
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL arst_setup got v=%b want 1", rsp_valid); end
    req_valid = '1;
    #2 rst_n = 0;
    #1;
    tests++; if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== 2'd0 || req_ready !== '0) begin
      fails++; $display("FAIL arst_now got v=%b d=%h id=%0d rdy=%b want 0/0/0/0", rsp_valid, rsp_data, rsp_id, req_ready);
    end
    @(posedge clk); #1;
    rst_n = 1; model_reset();
    tick();
    tests++; if (rsp_id !== 2'd0 || obs_ready !== 4'b0001 || rsp_valid !== 1'b1) begin
      fails++; $display("FAIL arst_ptr got id=%0d rdy=%b want id=0 rdy=0001", rsp_id, obs_ready);
    end
    req_valid = '0;
    tick();
  endtask

`ifdef LOGIC_ARB_STATS_EN
  task automatic test_stats();
    rst_n = 0; #1; rst_n = 1; model_reset();
    set_req(1, $urandom, $urandom, 2'd0);
    req_valid = 4'b0010; rsp_ready = 1;
    tick();
    rsp_ready = 0;
    for (int k = 0; k < 3; k++) tick();
    tests++; if (stall_cnt !== 16'd3 || m_stall != 3) begin fails++; $display("FAIL stall_cnt got %0d want 3", stall_cnt); end
    @(negedge clk); force dut.stall_cnt = 16'hFFFD; #1; release dut.stall_cnt;
    for (int k = 0; k < 4; k++) @(posedge clk);
    #1;
    tests++; if (stall_cnt !== 16'hFFFF) begin fails++; $display("FAIL stall_sat got %h want FFFF", stall_cnt); end
    req_valid = '0; rsp_ready = 1;
    tick();
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_round_robin();
    test_ops();
    test_backpressure();
    test_random();
    test_async_reset();
`ifdef LOGIC_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
